multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle main controller for the simple CPU. It sequences each instruction through fetch, decode, execute, memory and write-back states. It holds a request/acknowledge handshake with instruction/data memory and drives the datapath enables. It also produces the 3-bit ALU operation class consumed by the ALU control decoder, which resolves R-type funct fields.

## Interface
- No parameters.
- clk_i  in  1  system clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- instr_i  in  32  memory read data; opcode [31:26], rt [20:16], funct [5:0]
- mem_ack_i  in  1  memory completes the current request
- zero_i  in  1  ALU zero flag, valid in EXEC
- mem_req_o  out  1  memory request, held until acknowledged
- mem_we_o  out  1  request is a store
- mem_addr_sel_o  out  1  0 = PC address, 1 = ALU result address
- ir_write_o  out  1  latch instruction register
- pc_write_o  out  1  PC update
- pc_src_o  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = register (jr)
- reg_write_o  out  1  register file write
- reg_dst_o  out  2  0 = rt, 1 = rd, 2 = r31
- mem_to_reg_o  out  1  write-back source is memory
- alu_src_o  out  1  ALU B operand is the immediate
- alu_op_o  out  3  ALU operation class
- illegal_o  out  1  one-cycle pulse on an undefined opcode

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. State is encoded in 3 bits.
- FETCH:
  - mem_req_o=1 and mem_addr_sel_o=0.
  - On mem_ack_i=1: ir_write_o=1, pc_write_o=1, pc_src_o=0.
  - opcode, rt and funct are captured internally on the same edge, then the FSM moves to DECODE.
  - With no ack the FSM stays in FETCH.
- DECODE: the captured opcode is classified.
  - Undefined opcode: illegal_o=1, next state FETCH, no other enables.
  - Otherwise next state EXEC.
- alu_op_o is driven from the captured opcode in EXEC, MEM and WB, and is 0 elsewhere:
  - R-type (0x00) -> 0
  - beq (0x04) -> 1
  - bltz (0x01, rt=0) -> 2
  - addi (0x08), lw (0x23), sw (0x2B) -> 3
  - sltiu (0x0B) -> 4
  - ori (0x0D) -> 5
  - lui (0x0F) -> 6
  - Code 7 is never emitted.
  - Opcode 0x01 with rt≠0 is undefined.
- EXEC:
  - alu_src_o=1 for every class except R-type, beq and bltz.
  - beq and bltz: pc_write_o=zero_i, pc_src_o=1, next state FETCH.
  - j (0x02): pc_write_o=1, pc_src_o=2, next state FETCH.
  - jal (0x03): pc_write_o=1, pc_src_o=2, reg_write_o=1, reg_dst_o=2, next state FETCH.
  - R-type with funct=0x08 (jr): pc_write_o=1, pc_src_o=3, next state FETCH.
  - lw and sw: next state MEM.
  - All others: next state WB.
- MEM:
  - mem_req_o=1, mem_addr_sel_o=1, mem_we_o=1 for sw.
  - The FSM holds until mem_ack_i.
  - On ack: sw goes to FETCH; lw goes to WB, and instr_i is taken as load data by the datapath on that edge.
- WB:
  - reg_write_o=1; reg_dst_o=1 for R-type, 0 otherwise; mem_to_reg_o=1 for lw.
  - Next state FETCH.
- All outputs not listed for a state are 0.

## Timing
- Outputs are combinational from state, captured fields, mem_ack_i and zero_i. No output depends combinationally on instr_i.
- Reset:
  - While rst_i=1, every output is forced to 0 and the next state is FETCH.
  - mem_req_o=1 in the first cycle after rst_i falls.
  - Reset in any state, including mid-handshake, abandons the request and discards captured fields.
- Cycles per instruction with zero-wait ack (ack in the same cycle as req):
  - branch, jump, jr, jal: 3
  - R-type, immediate ops, sw: 4
  - lw: 5
  - illegal: 2
- Each wait cycle adds one cycle.
- Handshake rules:
  - mem_req_o, mem_we_o and mem_addr_sel_o are stable from assertion until the cycle ack is seen.
  - mem_ack_i outside FETCH/MEM is ignored.
  - A single ack consumes exactly one request.
- Simultaneous rst_i and mem_ack_i: reset wins and nothing is latched.

## Structure
- Shared package ctrl_pkg holds:
  - the state enum;
  - opcode constants (OP_RTYPE, OP_BLTZ, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI, OP_LW, OP_SW);
  - FUNCT_JR;
  - ALUOP_* codes 0-6;
  - pc_src and reg_dst encodings.
- The ALU control decoder imports the ALUOP_* codes from the same package.
- One sub-module, main_decoder: purely combinational, maps opcode/rt/funct to instruction class, alu_op and a legal flag. multicycle_ctrl holds the FSM and the captured fields.

## Test plan
- Reset held 3 cycles mid-MEM with mem_ack_i=1 -> all outputs 0 throughout; mem_req_o=1, mem_addr_sel_o=0 the cycle after release.
- add (0x012A4020), zero-wait ack -> FETCH/DECODE/EXEC/WB in 4 cycles; alu_op_o=0 in EXEC/WB; reg_write_o=1 with reg_dst_o=1 in WB only.
- lw (0x8D280004), ack delayed 2 cycles in both FETCH and MEM -> 9 cycles total; mem_req_o steady while waiting; mem_to_reg_o=1, alu_op_o=3 in WB.
- beq with zero_i=1, then zero_i=0 -> pc_write_o=1/pc_src_o=1 in EXEC for the first only; both return to FETCH after 3 cycles.
- jr (funct 0x08) and jal (0x0C000010) -> pc_src_o=3; pc_src_o=2 with reg_dst_o=2, reg_write_o=1; no WB state visited.
- Opcode 0x3F, and opcode 0x01 with rt=1 -> illegal_o pulses for 1 cycle in DECODE, no writes, FETCH next.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller, its decoder and the
// ALU control decoder that consumes the ALU operation class.
package ctrl_pkg;

  // Controller sequencing states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // Instruction classes as seen by the sequencer
  typedef enum logic [2:0] {
    CLS_RTYPE  = 3'd0,
    CLS_JR     = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_JUMP   = 3'd3,
    CLS_JAL    = 3'd4,
    CLS_LOAD   = 3'd5,
    CLS_STORE  = 3'd6,
    CLS_IMM    = 3'd7
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [2:0] ALUOP_RTYPE = 3'd0;
  localparam logic [2:0] ALUOP_BEQ   = 3'd1;
  localparam logic [2:0] ALUOP_BLTZ  = 3'd2;
  localparam logic [2:0] ALUOP_ADD   = 3'd3;
  localparam logic [2:0] ALUOP_SLTIU = 3'd4;
  localparam logic [2:0] ALUOP_ORI   = 3'd5;
  localparam logic [2:0] ALUOP_LUI   = 3'd6;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode classifier: instruction class, ALU operation class
// and a legal flag from the captured opcode/rt/funct fields.
module main_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [4:0]   rt,
  input  logic [5:0]   funct,
  output instr_class_t instr_class,
  output logic [2:0]   alu_op,
  output logic         legal
);

  // Opcode lookup; anything not listed falls through as illegal
  always_comb begin
    instr_class = CLS_IMM;
    alu_op      = ALUOP_RTYPE;
    legal       = 1'b1;
    case (opcode)
      OP_RTYPE: instr_class = (funct == FUNCT_JR) ? CLS_JR : CLS_RTYPE;
      OP_BLTZ: begin
        if (rt == 5'd0) begin
          instr_class = CLS_BRANCH;
          alu_op      = ALUOP_BLTZ;
        end else begin
          legal = 1'b0;
        end
      end
      OP_J:   instr_class = CLS_JUMP;
      OP_JAL: instr_class = CLS_JAL;
      OP_BEQ: begin
        instr_class = CLS_BRANCH;
        alu_op      = ALUOP_BEQ;
      end
      OP_ADDI:  alu_op = ALUOP_ADD;
      OP_SLTIU: alu_op = ALUOP_SLTIU;
      OP_ORI:   alu_op = ALUOP_ORI;
      OP_LUI:   alu_op = ALUOP_LUI;
      OP_LW: begin
        instr_class = CLS_LOAD;
        alu_op      = ALUOP_ADD;
      end
      OP_SW: begin
        instr_class = CLS_STORE;
        alu_op      = ALUOP_ADD;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// request handshake and datapath enables. Outputs depend only on state,
// the captured instruction fields, mem_ack_i and zero_i.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        mem_ack_i,
  input  logic        zero_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic        reg_write_o,
  output logic [1:0]  reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_o,
  output logic [2:0]  alu_op_o,
  output logic        illegal_o
);

  state_t       state, next_state;
  logic [5:0]   opcode_q;
  logic [4:0]   rt_q;
  logic [5:0]   funct_q;
  instr_class_t dec_class;
  logic [2:0]   dec_alu_op;
  logic         dec_legal;

  // Only opcode, rt and funct matter to control; the other bits feed the datapath
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_i[25:21], instr_i[15:6]};

  main_decoder u_main_decoder (
    .opcode      (opcode_q),
    .rt          (rt_q),
    .funct       (funct_q),
    .instr_class (dec_class),
    .alu_op      (dec_alu_op),
    .legal       (dec_legal)
  );

  // State register and field capture on the acknowledged fetch; reset wins over ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_FETCH;
      opcode_q <= 6'd0;
      rt_q     <= 5'd0;
      funct_q  <= 6'd0;
    end else begin
      state <= next_state;
      if (state == ST_FETCH && mem_ack_i) begin
        opcode_q <= instr_i[31:26];
        rt_q     <= instr_i[20:16];
        funct_q  <= instr_i[5:0];
      end
    end
  end

  // Next-state and output decode; everything idles at 0 while reset is held
  always_comb begin
    next_state     = state;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    pc_src_o       = PC_SRC_SEQ;
    reg_write_o    = 1'b0;
    reg_dst_o      = REG_DST_RT;
    mem_to_reg_o   = 1'b0;
    alu_src_o      = 1'b0;
    alu_op_o       = ALUOP_RTYPE;
    illegal_o      = 1'b0;
    if (rst_i) begin
      next_state = ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ack_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            next_state = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_legal) begin
            next_state = ST_EXEC;
          end else begin
            illegal_o  = 1'b1;
            next_state = ST_FETCH;
          end
        end
        ST_EXEC: begin
          alu_op_o   = dec_alu_op;
          alu_src_o  = !(dec_class == CLS_RTYPE || dec_class == CLS_JR ||
                         dec_class == CLS_BRANCH);
          next_state = ST_WB;
          case (dec_class)
            CLS_BRANCH: begin
              pc_write_o = zero_i;
              pc_src_o   = PC_SRC_BRANCH;
              next_state = ST_FETCH;
            end
            CLS_JUMP: begin
              pc_write_o = 1'b1;
              pc_src_o   = PC_SRC_JUMP;
              next_state = ST_FETCH;
            end
            CLS_JAL: begin
              pc_write_o  = 1'b1;
              pc_src_o    = PC_SRC_JUMP;
              reg_write_o = 1'b1;
              reg_dst_o   = REG_DST_RA;
              next_state  = ST_FETCH;
            end
            CLS_JR: begin
              pc_write_o = 1'b1;
              pc_src_o   = PC_SRC_REG;
              next_state = ST_FETCH;
            end
            CLS_LOAD, CLS_STORE: next_state = ST_MEM;
            default: next_state = ST_WB;
          endcase
        end
        ST_MEM: begin
          alu_op_o       = dec_alu_op;
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = (dec_class == CLS_STORE);
          if (mem_ack_i) begin
            next_state = (dec_class == CLS_STORE) ? ST_FETCH : ST_WB;
          end
        end
        ST_WB: begin
          alu_op_o     = dec_alu_op;
          reg_write_o  = 1'b1;
          reg_dst_o    = (dec_class == CLS_RTYPE) ? REG_DST_RD : REG_DST_RT;
          mem_to_reg_o = (dec_class == CLS_LOAD);
          next_state   = ST_FETCH;
        end
        default: next_state = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded
// from the instruction-set rules into a per-cycle list of expected outputs.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_i = 32'd0;
  logic        mem_ack_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o;
  logic [1:0]  pc_src_o, reg_dst_o;
  logic        reg_write_o, mem_to_reg_o, alu_src_o, illegal_o;
  logic [2:0]  alu_op_o;
  logic [15:0] dut_vec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ack;
    logic        zero;
    logic        fetch;
    logic [15:0] vec;
  } step_t;

  step_t q[$];

  multicycle_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_i        (instr_i),
    .mem_ack_i      (mem_ack_i),
    .zero_i         (zero_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_sel_o (mem_addr_sel_o),
    .ir_write_o     (ir_write_o),
    .pc_write_o     (pc_write_o),
    .pc_src_o       (pc_src_o),
    .reg_write_o    (reg_write_o),
    .reg_dst_o      (reg_dst_o),
    .mem_to_reg_o   (mem_to_reg_o),
    .alu_src_o      (alu_src_o),
    .alu_op_o       (alu_op_o),
    .illegal_o      (illegal_o)
  );

  // 10 time-unit clock
  always #5 clk_i = ~clk_i;

  // All outputs packed for single-compare per cycle
  assign dut_vec = {mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o,
                    pc_src_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_o,
                    alu_op_o, illegal_o};

  function automatic logic [15:0] mk(input logic req, input logic we, input logic asel,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic rw, input logic [1:0] rd, input logic m2r,
                                     input logic asrc, input logic [2:0] aop, input logic ill);
    return {req, we, asel, irw, pcw, pcs, rw, rd, m2r, asrc, aop, ill};
  endfunction

  // Expand one instruction into expected cycles from the ISA rules
  task automatic build_instr(input logic [31:0] instr, input int w_fetch, input int w_mem,
                             input logic z);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    logic       legal, is_r, is_jr, is_br, is_j, is_jal, is_lw, is_sw, asrc;
    logic [2:0] aop;
    step_t      s;
    op = instr[31:26];
    rt = instr[20:16];
    fn = instr[5:0];
    legal = 1'b1; aop = 3'd0;
    is_r = 1'b0; is_jr = 1'b0; is_br = 1'b0; is_j = 1'b0; is_jal = 1'b0;
    is_lw = 1'b0; is_sw = 1'b0;
    if (op == 6'h00) begin
      if (fn == 6'h08) is_jr = 1'b1; else is_r = 1'b1;
    end else if (op == 6'h04) begin
      is_br = 1'b1; aop = 3'd1;
    end else if (op == 6'h01) begin
      if (rt == 5'd0) begin is_br = 1'b1; aop = 3'd2; end else legal = 1'b0;
    end else if (op == 6'h02) is_j = 1'b1;
    else if (op == 6'h03) is_jal = 1'b1;
    else if (op == 6'h08) aop = 3'd3;
    else if (op == 6'h23) begin is_lw = 1'b1; aop = 3'd3; end
    else if (op == 6'h2B) begin is_sw = 1'b1; aop = 3'd3; end
    else if (op == 6'h0B) aop = 3'd4;
    else if (op == 6'h0D) aop = 3'd5;
    else if (op == 6'h0F) aop = 3'd6;
    else legal = 1'b0;

    for (int i = 0; i < w_fetch; i++) begin
      s.ack = 1'b0; s.zero = 1'($urandom); s.fetch = 1'b1;
      s.vec = mk(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'd0, 0);
      q.push_back(s);
    end
    s.ack = 1'b1; s.zero = 1'($urandom); s.fetch = 1'b1;
    s.vec = mk(1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 0, 0, 3'd0, 0);
    q.push_back(s);

    s.ack = 1'($urandom); s.zero = 1'($urandom); s.fetch = 1'b0;
    s.vec = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'd0, !legal);
    q.push_back(s);
    if (!legal) return;

    asrc = !(is_r || is_jr || is_br);
    s.ack = 1'($urandom); s.zero = 1'($urandom); s.fetch = 1'b0;
    if (is_br) begin
      s.zero = z;
      s.vec = mk(0, 0, 0, 0, z, 2'd1, 0, 2'd0, 0, asrc, aop, 0);
    end else if (is_j)
      s.vec = mk(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 0, asrc, aop, 0);
    else if (is_jal)
      s.vec = mk(0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 0, asrc, aop, 0);
    else if (is_jr)
      s.vec = mk(0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 0, asrc, aop, 0);
    else
      s.vec = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, asrc, aop, 0);
    q.push_back(s);
    if (is_br || is_j || is_jal || is_jr) return;

    if (is_lw || is_sw) begin
      for (int i = 0; i <= w_mem; i++) begin
        s.ack = (i == w_mem); s.zero = 1'($urandom); s.fetch = 1'b0;
        s.vec = mk(1, is_sw, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0, aop, 0);
        q.push_back(s);
      end
      if (is_sw) return;
    end

    s.ack = 1'($urandom); s.zero = 1'($urandom); s.fetch = 1'b0;
    s.vec = mk(0, 0, 0, 0, 0, 2'd0, 1, is_r ? 2'd1 : 2'd0, is_lw, 0, aop, 0);
    q.push_back(s);
  endtask

  // Drive one cycle's inputs after the rising edge, then wait for the falling edge
  task automatic step_cycle(input logic rst, input logic ack, input logic z,
                            input logic [31:0] instr);
    @(posedge clk_i);
    #1;
    rst_i = rst; mem_ack_i = ack; zero_i = z; instr_i = instr;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step_cycle(1'b1, 1'($urandom), 1'($urandom), $urandom);
      checks++;
      if (dut_vec !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_initial cyc%0d: got %h expected %h", i, dut_vec, 16'h0);
      end
    end
    // Run lw up to its MEM state, then reset there while ack is high
    build_instr(32'h8D280004, 0, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_cycle(1'b0, q[i].ack, q[i].zero, q[i].fetch ? 32'h8D280004 : $urandom);
      checks++;
      if (dut_vec !== q[i].vec) begin
        errors++;
        $display("[TB] FAIL reset_pre cyc%0d: got %h expected %h", i, dut_vec, q[i].vec);
      end
    end
    q.delete();
    for (int i = 0; i < 3; i++) begin
      step_cycle(1'b1, 1'b1, 1'($urandom), 32'hFFFFFFFF);
      checks++;
      if (dut_vec !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_mid_mem cyc%0d: got %h expected %h", i, dut_vec, 16'h0);
      end
    end
    step_cycle(1'b0, 1'b0, 1'b0, $urandom);
    checks++;
    if (dut_vec !== mk(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'd0, 0)) begin
      errors++;
      $display("[TB] FAIL reset_release: got %h expected %h", dut_vec,
               mk(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'd0, 0));
    end
  endtask

  task automatic test_add();
    build_instr(32'h012A4020, 0, 0, 1'b0);
    foreach (q[i]) begin
      step_cycle(1'b0, q[i].ack, q[i].zero, q[i].fetch ? 32'h012A4020 : $urandom);
      checks++;
      if (dut_vec !== q[i].vec) begin
        errors++;
        $display("[TB] FAIL add cyc%0d: got %h expected %h", i, dut_vec, q[i].vec);
      end
    end
    q.delete();
  endtask

  task automatic test_lw_wait();
    build_instr(32'h8D280004, 2, 2, 1'b0);
    checks++;
    if (q.size() != 9) begin
      errors++;
      $display("[TB] FAIL lw_cycles: got %0d expected 9", q.size());
    end
    foreach (q[i]) begin
      step_cycle(1'b0, q[i].ack, q[i].zero, q[i].fetch ? 32'h8D280004 : $urandom);
      checks++;
      if (dut_vec !== q[i].vec) begin
        errors++;
        $display("[TB] FAIL lw_wait cyc%0d: got %h expected %h", i, dut_vec, q[i].vec);
      end
    end
    q.delete();
  endtask

  task automatic test_branch();
    logic [31:0] list [4] = '{32'h11090003, 32'h11090003, 32'h04200005, 32'h04200005};
    for (int k = 0; k < 4; k++) begin
      build_instr(list[k], 0, 0, (k % 2) == 0);
      foreach (q[i]) begin
        step_cycle(1'b0, q[i].ack, q[i].zero, q[i].fetch ? list[k] : $urandom);
        checks++;
        if (dut_vec !== q[i].vec) begin
          errors++;
          $display("[TB] FAIL branch%0d cyc%0d: got %h expected %h", k, i, dut_vec, q[i].vec);
        end
      end
      q.delete();
    end
  endtask

  task automatic test_jumps();
    logic [31:0] list [3] = '{32'h03E00008, 32'h0C000010, 32'h08000020};
    for (int k = 0; k < 3; k++) begin
      build_instr(list[k], k, 0, 1'b0);
      foreach (q[i]) begin
        step_cycle(1'b0, q[i].ack, q[i].zero, q[i].fetch ? list[k] : $urandom);
        checks++;
        if (dut_vec !== q[i].vec) begin
          errors++;
          $display("[TB] FAIL jump%0d cyc%0d: got %h expected %h", k, i, dut_vec, q[i].vec);
        end
      end
      q.delete();
    end
  endtask

  task automatic test_illegal();
    logic [31:0] list [3] = '{32'hFC000000, 32'h04210005, 32'h012A4020};
    for (int k = 0; k < 3; k++) begin
      build_instr(list[k], 0, 0, 1'b0);
      foreach (q[i]) begin
        step_cycle(1'b0, q[i].ack, q[i].zero, q[i].fetch ? list[k] : $urandom);
        checks++;
        if (dut_vec !== q[i].vec) begin
          errors++;
          $display("[TB] FAIL illegal%0d cyc%0d: got %h expected %h", k, i, dut_vec, q[i].vec);
        end
      end
      q.delete();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  ops [12] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08,
                               6'h0B, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 14);
    if (sel < 12) w[31:26] = ops[sel];
    else if (sel == 12) begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
    else if (sel == 13) begin w[31:26] = 6'h01; w[20:16] = 5'd0; end
    return w;
  endfunction

  task automatic test_back_to_back();
    logic [31:0] instr;
    for (int k = 0; k < 80; k++) begin
      instr = rand_instr();
      build_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      foreach (q[i]) begin
        step_cycle(1'b0, q[i].ack, q[i].zero, q[i].fetch ? instr : $urandom);
        checks++;
        if (dut_vec !== q[i].vec) begin
          errors++;
          $display("[TB] FAIL random%0d instr %h cyc%0d: got %h expected %h",
                   k, instr, i, dut_vec, q[i].vec);
        end
      end
      q.delete();
    end
  endtask

  initial begin
    $display("[TB] starting multicycle_ctrl bench");
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_illegal();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
